// File: rtl/target_sequencer.sv
// rtl/target_sequencer.sv - reaction-game target lamp sequencer with hit/miss judging
// Lights one of three targets per round, judges synchronized player edges, counts rounds.
module target_sequencer #(
  parameter int unsigned TICK_DIV  = 2000000,
  parameter int unsigned LIT_TICKS = 8,
  parameter int unsigned GAP_TICKS = 2,
  parameter int unsigned ROUNDS    = 30,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       enable,
  input  logic [2:0] sense,
  output logic [2:0] led,
  output logic       hit,
  output logic       miss,
  output logic [7:0] round_cnt,
  output logic       busy,
  output logic       game_over
);

  localparam int unsigned PW   = $clog2(TICK_DIV);
  localparam int unsigned TMAX = (LIT_TICKS > GAP_TICKS) ? LIT_TICKS : GAP_TICKS;
  localparam int unsigned TW   = (TMAX < 2) ? 1 : $clog2(TMAX);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0] LIT_LAST   = TW'(LIT_TICKS - 1);
  localparam logic [7:0]    ROUNDS_END = 8'(ROUNDS);
  localparam logic [15:0]   LFSR_TAPS  = 16'hB400;

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_LIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [2:0]    sync1_q, sync2_q, prev_q, rise_q;
  logic [2:0]    led_q, led_d;
  logic          hit_q, hit_d, miss_q, miss_d;
  logic [7:0]    round_q, round_d;
  logic          busy_q, over_q;

  logic          run, tick, correct, wrong, round_end;
  logic [1:0]    t_sel;
  logic [2:0]    rise_ok;
  logic [7:0]    round_inc;

  // Two sync flops, a history flop, and a registered edge so the decision
  // lands on the fourth clock after the input rises.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 3'b0;
      sync2_q <= 3'b0;
      prev_q  <= 3'b0;
      rise_q  <= 3'b0;
    end else begin
      sync1_q <= sense;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
    end
  end

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  assign t_sel  = (lfsr_q[1:0] == 2'd3) ? 2'd0 : lfsr_q[1:0];

  assign run       = ((state_q == S_GAP) || (state_q == S_LIT)) && enable;
  assign tick      = run && (presc_q == PRESC_LAST);
  assign rise_ok   = enable ? rise_q : 3'b000;
  assign correct   = |(rise_ok & led_q);
  assign wrong     = |(rise_ok & ~led_q);
  assign round_inc = round_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    tcnt_d    = tcnt_q;
    led_d     = led_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    round_d   = round_q;
    round_end = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        led_d = 3'b000;
        if (start) begin
          state_d = S_GAP;
          round_d = 8'd0;
        end
      end
      S_GAP: begin
        led_d = 3'b000;
        if (run) begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            if (tcnt_q == GAP_LAST) begin
              state_d = S_LIT;
              led_d   = 3'b001 << t_sel;
            end else begin
              tcnt_d = tcnt_q + 1'b1;
            end
          end
        end
      end
      S_LIT: begin
        if (run) begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (correct) begin
            hit_d     = 1'b1;
            round_end = 1'b1;
          end else if (wrong || (tick && (tcnt_q == LIT_LAST))) begin
            miss_d    = 1'b1;
            round_end = 1'b1;
          end else if (tick) begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        if (round_end) begin
          led_d   = 3'b000;
          round_d = round_inc;
          state_d = (round_inc == ROUNDS_END) ? S_DONE : S_GAP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every state change restarts the timing from zero.
    if (state_d != state_q) begin
      presc_d = '0;
      tcnt_d  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      tcnt_q  <= '0;
      lfsr_q  <= LFSR_SEED;
      led_q   <= 3'b000;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      round_q <= 8'd0;
      busy_q  <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
      lfsr_q  <= lfsr_d;
      led_q   <= led_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      round_q <= round_d;
      busy_q  <= (state_d == S_GAP) || (state_d == S_LIT);
      over_q  <= (state_d == S_DONE);
    end
  end

  assign led       = led_q;
  assign hit       = hit_q;
  assign miss      = miss_q;
  assign round_cnt = round_q;
  assign busy      = busy_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_target_sequencer.sv
// tb/tb_target_sequencer.sv - self-checking bench for target_sequencer
// Round outcomes come from a table and from random rounds judged by a timing-rule model.
module tb_target_sequencer;

  localparam int TICK_DIV = 4;
  localparam int LIT_T    = 3;
  localparam int GAP_T    = 2;
  localparam int NROUNDS  = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  localparam int GAP_CLK = TICK_DIV * GAP_T;
  localparam int LIT_CLK = TICK_DIV * LIT_T;
  localparam int SYNC_LAT = 4;

  logic       clock = 1'b0;
  logic       reset, start, enable;
  logic [2:0] sense;
  logic [2:0] led;
  logic       hit, miss, busy, game_over;
  logic [7:0] round_cnt;

  int checks = 0;
  int errors = 0;
  int exp_round = 0;
  int cur_t = 0;
  logic [15:0] m_lfsr;

  target_sequencer #(
    .TICK_DIV(TICK_DIV), .LIT_TICKS(LIT_T), .GAP_TICKS(GAP_T),
    .ROUNDS(NROUNDS), .LFSR_SEED(SEED)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .enable(enable), .sense(sense),
    .led(led), .hit(hit), .miss(miss), .round_cnt(round_cnt),
    .busy(busy), .game_over(game_over)
  );

  always #5 clock = ~clock;

  // Polynomial x^16+x^14+x^13+x^11+1 in right-shifting Galois form.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] mask;
    mask = 16'((1 << (16 - 1)) | (1 << (14 - 1)) | (1 << (13 - 1)) | (1 << (11 - 1)));
    return (v >> 1) ^ (v[0] ? mask : 16'h0);
  endfunction

  always @(posedge clock) m_lfsr <= reset ? SEED : lfsr_step(m_lfsr);

  function automatic int tmap(input logic [15:0] v);
    int r;
    r = int'(v[1:0]);
    return (r == 3) ? 0 : r;
  endfunction

  function automatic logic [2:0] onehot(input int i);
    return 3'(1 << i);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // act: 0 none, 1 correct target, 2 wrong target, 3 both on the same clock.
  function automatic void predict(input int act, input int d, output bit e_hit, output int e_lat);
    bit responds;
    responds = (act != 0) && (d + SYNC_LAT <= LIT_CLK);
    e_hit = responds && (act == 1 || act == 3);
    e_lat = responds ? d + SYNC_LAT : LIT_CLK;
  endfunction

  typedef struct {
    int act;
    int d;
    bit exp_hit;
    int exp_lat;
  } vec_t;

  vec_t tbl[6];

  task automatic wait_led(input bit poke, output bit ok);
    logic [15:0] prev;
    int lat;
    int stray;
    lat = -1;
    stray = 0;
    for (int c = 1; c <= 60; c++) begin
      prev = m_lfsr;
      @(negedge clock);
      if (hit || miss) stray++;
      if (poke) start = (c <= 3);
      if (led != 3'b000) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    check("no_stray_pulse_in_gap", stray, 0);
    check("gap_length", lat, GAP_CLK);
    ok = (lat > 0);
    cur_t = tmap(prev);
    if (ok) check("led_target", led, onehot(cur_t));
  endtask

  task automatic end_of_round_checks(input string tag);
    exp_round++;
    check({tag, "_led_cleared"}, led, 0);
    check({tag, "_round_cnt"}, round_cnt, exp_round);
    check({tag, "_game_over"}, game_over, (exp_round == NROUNDS));
    check({tag, "_busy"}, busy, (exp_round != NROUNDS));
  endtask

  task automatic play_round(input int act, input int d, input bit e_hit, input int e_lat, input bit poke);
    bit ok, done, both;
    int lat;
    logic [2:0] pat;
    logic g_hit, g_miss;
    wait_led(poke, ok);
    if (!ok) return;
    case (act)
      1: pat = onehot(cur_t);
      2: pat = onehot((cur_t + 1) % 3);
      3: pat = onehot(cur_t) | onehot((cur_t + 2) % 3);
      default: pat = 3'b000;
    endcase
    done = 0; both = 0; lat = -1; g_hit = 0; g_miss = 0;
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) begin
        @(negedge clock);
        if (hit && miss) both = 1;
        if (!done && (hit || miss)) begin
          done = 1; lat = c; g_hit = hit; g_miss = miss;
        end
      end
      if (c == d) sense = pat;
      if (c == d + 1) sense = 3'b000;
      if (done && c >= d + 1) break;
    end
    sense = 3'b000;
    check("round_event_latency", lat, e_lat);
    check("round_hit", g_hit, e_hit);
    check("round_miss", g_miss, !e_hit);
    check("hit_miss_exclusive", both, 0);
    if (done) end_of_round_checks("round");
  endtask

  task automatic do_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    exp_round = 0;
    check("start_busy", busy, 1);
    check("start_game_over", game_over, 0);
    check("start_round_cnt", round_cnt, 0);
  endtask

  task automatic random_round(input bit poke);
    int act, d, e_lat;
    bit e_hit;
    act = int'($urandom_range(3, 0));
    d = int'($urandom_range(11, 0));
    predict(act, d, e_hit, e_lat);
    play_round(act, d, e_hit, e_lat, poke);
  endtask

  task automatic pause_round();
    bit ok;
    int bad, lat;
    logic [2:0] held;
    logic g_hit, g_miss;
    wait_led(0, ok);
    if (!ok) return;
    held = led;
    bad = 0;
    repeat (5) begin
      @(negedge clock);
      if (hit || miss) bad++;
    end
    enable = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clock);
      if (c == 10) sense = onehot(cur_t);
      if (c == 12) sense = 3'b000;
      if (hit || miss || led != held) bad++;
    end
    enable = 1'b1;
    check("pause_no_event_led_held", bad, 0);
    lat = -1; g_hit = 0; g_miss = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (hit || miss) begin
        lat = c; g_hit = hit; g_miss = miss;
        break;
      end
    end
    check("pause_resume_latency", lat, LIT_CLK - 5);
    check("pause_timeout_miss", g_miss, 1);
    check("pause_timeout_hit", g_hit, 0);
    if (lat > 0) end_of_round_checks("pause");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_lat, changes;
    bit e_hit;

    tbl[0] = '{act: 0, d: 0, exp_hit: 0, exp_lat: 12};
    tbl[1] = '{act: 1, d: 2, exp_hit: 1, exp_lat: 6};
    tbl[2] = '{act: 2, d: 1, exp_hit: 0, exp_lat: 5};
    tbl[3] = '{act: 3, d: 3, exp_hit: 1, exp_lat: 7};
    tbl[4] = '{act: 1, d: 8, exp_hit: 1, exp_lat: 12};
    tbl[5] = '{act: 1, d: 9, exp_hit: 0, exp_lat: 12};

    reset = 1'b1; start = 1'b0; enable = 1'b1; sense = 3'b000;
    repeat (3) @(negedge clock);
    check("reset_led", led, 0);
    check("reset_hit_miss", {hit, miss}, 0);
    check("reset_round_cnt", round_cnt, 0);
    check("reset_busy_over", {busy, game_over}, 0);
    reset = 1'b0;

    do_start();
    for (int i = 0; i < 3; i++)
      play_round(tbl[i].act, tbl[i].d, tbl[i].exp_hit, tbl[i].exp_lat, 1'b0);

    repeat (10) @(negedge clock);
    check("done_holds_round_cnt", round_cnt, NROUNDS);
    check("done_holds_game_over", game_over, 1);

    do_start();
    for (int i = 3; i < 6; i++)
      play_round(tbl[i].act, tbl[i].d, tbl[i].exp_hit, tbl[i].exp_lat, 1'b1);

    do_start();
    pause_round();
    random_round(1'b0);
    random_round(1'b1);

    for (int g = 0; g < 3; g++) begin
      do_start();
      for (int r = 0; r < NROUNDS; r++) random_round(r == 1);
    end

    do_start();
    predict(1, 0, e_hit, e_lat);
    play_round(1, 0, e_hit, e_lat, 1'b0);
    begin
      bit ok;
      wait_led(0, ok);
    end
    repeat (2) @(negedge clock);
    check("pre_reset_lit", led != 3'b000, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midgame_reset_led", led, 0);
    check("midgame_reset_round_cnt", round_cnt, 0);
    check("midgame_reset_busy_over", {busy, game_over}, 0);
    changes = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if ({led, hit, miss, round_cnt, busy, game_over} != 15'd0) changes++;
    end
    check("idle_stays_quiet", changes, 0);

    do_start();
    predict(2, 4, e_hit, e_lat);
    play_round(2, 4, e_hit, e_lat, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
